fp_round_pipe: RTL and testbench
================================

// Module: fp_round_pipe
// PURPOSE
//   Parametrised, pipelined successor to the combinational fpcvt rounder.
//   Rounds an {exponent, significand, guard bits} triple to EXP_W/SIG_W.
//   Selectable rounding mode; renormalises on significand carry; saturates on exponent overflow.
//   Sits between the leading-zero/extract stage and output packing, with a valid/ready stream.
// PARAMETERS
//   EXP_W  3  exponent width
//   SIG_W  4  significand width, explicit bits
//   GRD_W  1  bits below the significand LSB; MSB = round bit, rest OR'd into sticky (GRD_W>=1)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      input beat valid
//   in_ready   out  1      block accepts the input beat this cycle
//   in_exp     in   EXP_W  unrounded exponent
//   in_sig     in   SIG_W  unrounded significand
//   in_grd     in   GRD_W  guard bits (fifth_bit when GRD_W=1)
//   in_mode    in   2      00 truncate, 01 round-half-up, 10 round-nearest-even, 11 same as 01
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts the result
//   out_exp    out  EXP_W  rounded exponent
//   out_sig    out  SIG_W  rounded significand
//   out_ovf    out  1      saturation occurred (only with FPRND_OVF_FLAG_EN)
// BEHAVIOUR
//   Reset: out_valid=0, out_exp=0, out_sig=0, out_ovf=0, all stage valids 0; in_ready=0 while rst=1.
//   Transfer happens on a clock edge with valid&ready both high. Inputs and mode are sampled together.
//   Two register stages, S1 and S2. Latency is 2 cycles from input accept to out_valid when unstalled.
//   Throughput is 1 beat/cycle. No bubbles while out_ready=1.
//   in_ready = !rst & (!s1_v | !s2_v | out_ready); it is combinational on out_ready, with no comb path from in_valid.
//   S1 advances into S2 when !s2_v | out_ready. S2 holds its data stable while out_valid & !out_ready.
//   S1 (round decision): r = in_grd[GRD_W-1]; s = |in_grd[GRD_W-2:0], and s=0 when GRD_W=1.
//     Increment inc: mode00 -> 0; mode01/11 -> r; mode10 -> r & (s | in_sig[0]).
//     Register sum = {1'b0,in_sig} + inc as SIG_W+1 bits, plus the exponent and exp_max = &in_exp.
//   S2 (normalise/saturate), from the carry c = sum[SIG_W]:
//     c=0             -> exp = exp, sig = sum[SIG_W-1:0]
//     c=1, !exp_max   -> exp = exp+1, sig = sum[SIG_W:1] (i.e. 100..0)
//     c=1,  exp_max   -> exp = all ones, sig = all ones (saturate), ovf=1
//   An input already at max with no increment passes unchanged, and ovf=0.
//   Simultaneous accept and drain with both stages full: both shift in the same cycle, with no loss or duplication.
//   Reset mid-stream: all in-flight beats are discarded; the first beat after reset release is handled normally.
//   Beats are always delivered in order. Unknown mode values are impossible, because 11 is defined.
// CONFIGURATION
//   FPRND_OVF_FLAG_EN defined: out_ovf is present, registered alongside out_exp/out_sig.
//     It is 1 only on saturated beats and is held stable during a stall.
//   FPRND_OVF_FLAG_EN undefined: out_ovf port and its flop are absent. Saturation behaviour is identical.
// TESTING (defaults EXP_W=3, SIG_W=4, GRD_W=1, out_ready=1 unless stated)
//   exp=111 sig=1111 grd=1 mode=01 -> 2 cycles later exp=111 sig=1111 (ovf=1 when enabled).
//   exp=010 sig=1111 grd=1 mode=01 -> exp=011 sig=1000. Same input with mode=00 -> exp=010 sig=1111.
//   mode=10: sig=0100 grd=1 -> 0100 (tie to even). sig=0101 grd=1 -> 0110, exp unchanged.
//   GRD_W=3, mode=10: sig=0100 grd=101 -> 0101 (sticky breaks tie). grd=011 -> 0100.
//   Stream 5 beats back-to-back and hold out_ready=0 for 4 cycles -> in_ready drops after 2 accepts.
//     Outputs then appear in order with none lost; out_* stay stable throughout the stall.
//   Assert rst for 1 cycle with 2 beats in flight -> out_valid=0, outputs 0.
//     Next beat after release appears exactly 2 cycles after its accept.

Source files
------------

// File: rtl/fp_round_pipe.sv
// fp_round_pipe - two-stage valid/ready rounder: S1 round decision, S2 renormalise/saturate.
// Optional out_ovf saturation flag enabled by defining FPRND_OVF_FLAG_EN.
module fp_round_pipe #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int GRD_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SIG_W-1:0] in_sig,
  input  logic [GRD_W-1:0] in_grd,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig
`ifdef FPRND_OVF_FLAG_EN
  ,
  output logic             out_ovf
`endif
);

  logic             s1_v;
  logic             s2_v;
  logic [SIG_W:0]   s1_sum;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_max;

  logic             s2_adv;
  logic             accept;
  logic             rnd;
  logic             sticky;
  logic             inc;
  logic [SIG_W:0]   sum_d;
  logic [EXP_W-1:0] n_exp;
  logic [SIG_W-1:0] n_sig;
  logic             n_sat;

  assign s2_adv    = !s2_v || out_ready;
  assign in_ready  = !rst && (!s1_v || !s2_v || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_v;

  // Round bit is the guard MSB; every lower guard bit folds into sticky.
  always_comb begin
    rnd    = in_grd[GRD_W-1];
    sticky = 1'b0;
    for (int i = 0; i < GRD_W - 1; i++) begin
      sticky = sticky | in_grd[i];
    end
    case (in_mode)
      2'b00:   inc = 1'b0;
      2'b10:   inc = rnd && (sticky || in_sig[0]);
      default: inc = rnd;
    endcase
    sum_d = {1'b0, in_sig} + (SIG_W + 1)'(inc);
  end

  always_comb begin
    n_exp = s1_exp;
    n_sig = s1_sum[SIG_W-1:0];
    n_sat = 1'b0;
    if (s1_sum[SIG_W]) begin
      if (s1_max) begin
        n_exp = '1;
        n_sig = '1;
        n_sat = 1'b1;
      end else begin
        n_exp = s1_exp + EXP_W'(1);
        n_sig = s1_sum[SIG_W:1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_sum <= '0;
      s1_exp <= '0;
      s1_max <= 1'b0;
    end else if (accept) begin
      s1_v   <= 1'b1;
      s1_sum <= sum_d;
      s1_exp <= in_exp;
      s1_max <= &in_exp;
    end else if (s2_adv) begin
      s1_v <= 1'b0;
    end
  end

  // S2 only reloads when it can advance, so a stalled beat stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      out_exp <= '0;
      out_sig <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_exp <= n_exp;
        out_sig <= n_sig;
      end
    end
  end

`ifdef FPRND_OVF_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ovf <= 1'b0;
    end else if (s2_adv && s1_v) begin
      out_ovf <= n_sat;
    end
  end
`endif

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe - directed and randomized checks of fp_round_pipe against a value-level model.
module tb_fp_round_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_exp = '0;
  logic [3:0] in_sig = '0;
  logic [0:0] in_grd = '0;
  logic [1:0] in_mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_exp;
  logic [3:0] out_sig;
  logic       out_ovf;

  logic       in_valid3 = 1'b0;
  logic       in_ready3;
  logic [2:0] in_exp3 = '0;
  logic [3:0] in_sig3 = '0;
  logic [2:0] in_grd3 = '0;
  logic [1:0] in_mode3 = '0;
  logic       out_valid3;
  logic [2:0] out_exp3;
  logic [3:0] out_sig3;
  logic       out_ovf3;

  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] held;
  logic       last_acc;
  logic       last_rdy;

  always #5 clk = ~clk;

`ifndef FPRND_OVF_FLAG_EN
  assign out_ovf  = 1'b0;
  assign out_ovf3 = 1'b0;
`endif

  fp_round_pipe #(.EXP_W(3), .SIG_W(4), .GRD_W(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_sig(in_sig), .in_grd(in_grd), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp), .out_sig(out_sig)
`ifdef FPRND_OVF_FLAG_EN
    , .out_ovf(out_ovf)
`endif
  );

  fp_round_pipe #(.EXP_W(3), .SIG_W(4), .GRD_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_exp(in_exp3), .in_sig(in_sig3), .in_grd(in_grd3), .in_mode(in_mode3),
    .out_valid(out_valid3), .out_ready(1'b1), .out_exp(out_exp3), .out_sig(out_sig3)
`ifdef FPRND_OVF_FLAG_EN
    , .out_ovf(out_ovf3)
`endif
  );

  // Value-level rounding reference: returns {ovf, exp[2:0], sig[3:0]}.
  function automatic logic [7:0] model(int e, int s, int g, int m, int gw);
    int r, st, inc, ns;
    r   = (g >> (gw - 1)) & 1;
    st  = ((g & ((1 << (gw - 1)) - 1)) != 0) ? 1 : 0;
    inc = (m == 0) ? 0 : (m == 2) ? (r & (st | (s & 1))) : r;
    ns  = s + inc;
    if (ns == 16) begin
      if (e == 7) return {1'b1, 3'd7, 4'd15};
      return {1'b0, 3'(e + 1), 4'd8};
    end
    return {1'b0, 3'(e), 4'(ns)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic obs, input logic expv);
`ifdef FPRND_OVF_FLAG_EN
    chk(tag, 32'(obs), 32'(expv));
`endif
  endtask

  task automatic step(input logic v, input logic [2:0] e, input logic [3:0] s,
                      input logic [0:0] g, input logic [1:0] m, input logic ordy);
    logic [7:0] x;
    @(negedge clk);
    in_valid = v; in_exp = e; in_sig = s; in_grd = g; in_mode = m; out_ready = ordy;
    #1;
    if (stall_prev) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_exp", 32'(out_exp), 32'(held[6:4]));
      chk("stall_sig", 32'(out_sig), 32'(held[3:0]));
      chk_ovf("stall_ovf", out_ovf, held[7]);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        x = q.pop_front();
        chk("sb_exp", 32'(out_exp), 32'(x[6:4]));
        chk("sb_sig", 32'(out_sig), 32'(x[3:0]));
        chk_ovf("sb_ovf", out_ovf, x[7]);
      end
    end
    last_rdy = in_ready;
    last_acc = in_valid && in_ready;
    if (last_acc) q.push_back(model(e, s, g, m, 1));
    stall_prev = out_valid && !out_ready;
    held = {out_ovf, out_exp, out_sig};
  endtask

  task automatic dir(input logic [2:0] e, input logic [3:0] s, input logic [0:0] g,
                     input logic [1:0] m, input logic [2:0] xe, input logic [3:0] xs,
                     input logic xo);
    step(1'b1, e, s, g, m, 1'b1);
    chk("dir_accept", 32'(last_acc), 32'd1);
    step(1'b0, 3'd0, 4'd0, 1'b0, 2'd0, 1'b1);
    chk("dir_lat1_valid", 32'(out_valid), 32'd0);
    step(1'b0, 3'd0, 4'd0, 1'b0, 2'd0, 1'b1);
    chk("dir_lat2_valid", 32'(out_valid), 32'd1);
    chk("dir_exp", 32'(out_exp), 32'(xe));
    chk("dir_sig", 32'(out_sig), 32'(xs));
    chk_ovf("dir_ovf", out_ovf, xo);
  endtask

  task automatic dir3(input logic [3:0] s, input logic [2:0] g, input logic [3:0] xs);
    @(negedge clk);
    in_valid3 = 1'b1; in_exp3 = 3'd2; in_sig3 = s; in_grd3 = g; in_mode3 = 2'b10;
    #1;
    chk("g3_ready", 32'(in_ready3), 32'd1);
    @(negedge clk);
    in_valid3 = 1'b0;
    @(negedge clk);
    #1;
    chk("g3_valid", 32'(out_valid3), 32'd1);
    chk("g3_exp", 32'(out_exp3), 32'd2);
    chk("g3_sig", 32'(out_sig3), 32'(xs));
    chk("g3_model", 32'(out_sig3), 32'(model(2, int'(s), int'(g), 2, 3) & 8'h0f));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 3'd0, 4'd0, 1'b0, 2'd0, 1'b1);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [11:0] beats[5];
    int nacc;
    int sent;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_exp", 32'(out_exp), 32'd0);
    chk("rst_out_sig", 32'(out_sig), 32'd0);
    chk_ovf("rst_out_ovf", out_ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    dir(3'd7, 4'd15, 1'b1, 2'b01, 3'd7, 4'd15, 1'b1);
    dir(3'd2, 4'd15, 1'b1, 2'b01, 3'd3, 4'd8, 1'b0);
    dir(3'd2, 4'd15, 1'b1, 2'b00, 3'd2, 4'd15, 1'b0);
    dir(3'd2, 4'd4, 1'b1, 2'b10, 3'd2, 4'd4, 1'b0);
    dir(3'd2, 4'd5, 1'b1, 2'b10, 3'd2, 4'd6, 1'b0);
    dir(3'd7, 4'd15, 1'b0, 2'b01, 3'd7, 4'd15, 1'b0);
    dir(3'd3, 4'd15, 1'b1, 2'b11, 3'd4, 4'd8, 1'b0);
    dir(3'd7, 4'd15, 1'b1, 2'b10, 3'd7, 4'd15, 1'b1);

    dir3(4'd4, 3'b101, 4'd5);
    dir3(4'd4, 3'b011, 4'd4);
    dir3(4'd4, 3'b100, 4'd4);
    dir3(4'd5, 3'b100, 4'd6);

    // Five back-to-back beats against a 4-cycle downstream stall.
    for (int i = 0; i < 5; i++) beats[i] = 12'($urandom);
    nacc = 0;
    sent = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, beats[sent][11:9], beats[sent][8:5], beats[sent][4], beats[sent][3:2], 1'b0);
      if (i >= 2) chk("stall_in_ready", 32'(last_rdy), 32'd0);
      if (last_acc) begin nacc++; sent++; end
    end
    chk("stall_accepts", 32'(nacc), 32'd2);
    for (int i = 0; i < 10 && sent < 5; i++) begin
      step(1'b1, beats[sent][11:9], beats[sent][8:5], beats[sent][4], beats[sent][3:2], 1'b1);
      if (last_acc) sent++;
    end
    chk("stall_all_sent", 32'(sent), 32'd5);
    drain();

    // Reset with two beats in flight.
    step(1'b1, 3'd1, 4'd3, 1'b1, 2'b01, 1'b1);
    step(1'b1, 3'd2, 4'd6, 1'b0, 2'b01, 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_exp", 32'(out_exp), 32'd0);
    chk("mid_rst_sig", 32'(out_sig), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    stall_prev = 1'b0;
    dir(3'd5, 4'd9, 1'b1, 2'b10, 3'd5, 4'd10, 1'b0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 3'($urandom), 4'($urandom), 1'($urandom), 2'($urandom),
           ($urandom % 4) != 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
